seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised Mealy serial sequence detector: watches a qualified 1-bit input stream and asserts a same-cycle match output whenever the last `PAT_W` accepted bits equal a runtime-loadable pattern. Overlapping and non-overlapping detection are both supported. An optional saturating match counter is included. The block sits between a serial bit source and control logic that consumes match events; it is the generalised successor of the fixed-pattern 4-bit detector.

## Interface
- `PAT_W`, default 4: pattern length in bits; legal range 2..32.
- `PAT_RESET`, default 4'b1101, `PAT_W` bits wide: pattern value after reset.
- `CNT_W`, default 8: match counter width; legal range 1..32.
- `clk` input 1: the single clock; every register updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `i` input 1: serial data bit.
- `i_valid` input 1: qualifies `i`; a bit is accepted only in cycles where this is 1.
- `overlap` input 1: 1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
- `load_pat` input 1: loads `pat_in` into the pattern register.
- `pat_in` input `PAT_W`: new pattern; MSB is the first bit of the sequence.
- `clr_cnt` input 1: clears the match counter (counter build only).
- `o` output 1: Mealy match flag, combinational from the current-cycle inputs.
- `match_cnt` output `CNT_W`: number of matches so far (counter build only).
- `cnt_sat` output 1: the counter has reached all-ones (counter build only).

## Operation
- State: `hist` (`PAT_W-1` bits, most recent bit at LSB), `fill` (0..`PAT_W-1`, number of valid bits in `hist`), and `pat` (`PAT_W` bits).
- `cand = {hist, i}`.
- `o = i_valid & ~load_pat & (fill == PAT_W-1) & (cand == pat)`.
- Accepted bit with no match: shift `i` into `hist`; `fill` increments and saturates at `PAT_W-1`.
- Accepted bit with a match and `overlap=1`: shift as normal, so the next pattern may reuse bits from this one.
- Accepted bit with a match and `overlap=0`: clear `hist` and set `fill` to 0; the next match needs `PAT_W` fresh bits.
- `i_valid=0`: `hist`, `fill` and the counter hold; `o=0`.
- `load_pat=1`: `pat <= pat_in`, and `hist` and `fill` clear. A bit arriving in the same cycle is discarded and `o=0`; load has priority.
- Counter: increments by 1 in each cycle where `o=1`. It saturates at 2^`CNT_W`-1 and never wraps. `cnt_sat = &match_cnt`.
- Counter priority, highest first: `rst`, then `clr_cnt`, then increment. If `clr_cnt` and `o` are both 1, the counter goes to 0 (the match is not counted), but `o` still asserts.
- `load_pat` does not affect the counter.
- Reset state: `hist`=0, `fill`=0, `pat`=`PAT_RESET`, `match_cnt`=0, `cnt_sat`=0. `o`=0 throughout reset and in the first cycle after it (because `fill`=0).
- Reset in the middle of a partial sequence discards all history.

## Timing
- `o` has zero latency: it is valid in the same cycle as the accepted bit, combinationally from `i`, `i_valid`, `load_pat` and the registers.
- `match_cnt` reflects a match one cycle after the `o` pulse.
- A pattern loaded in cycle N is compared against bits accepted from cycle N+1 onward. The earliest possible match is at cycle N+`PAT_W`.
- Back-to-back matches:
  - `overlap=1` with a self-overlapping pattern: possible on consecutive accepted bits (for example, pattern 1111 with an all-ones input).
  - `overlap=0`: at least `PAT_W` accepted bits apart.
- `overlap` may change in any cycle. It governs only the history update for a match occurring in that same cycle.

## Configuration
- Macro `SEQ_DETECT_CNT_EN`.
- Defined: `match_cnt`, `cnt_sat` and the counter register are built and behave as specified above.
- Undefined: no counter register exists. `match_cnt` is tied to 0 and `cnt_sat` is tied to 0. `clr_cnt` is ignored. Detection behaviour is identical to the defined case.

## Test plan
- Reset then default pattern 1101, `overlap=1`, `i_valid=1`, stream 1,1,0,1,1,0,1: `o`=1 on the 4th and 7th bits only; `match_cnt`=2 after the last bit.
- Same stream with `overlap=0`: `o`=1 on the 4th bit only. Then stream 1,1,0,1: `o`=1 on that 4th bit.
- `i_valid` gaps: bits 1,1,0,1 with `i_valid=0` idle cycles between them: `o`=1 only in the cycle of the final valid 1, and `o`=0 in every idle cycle.
- `load_pat` with `pat_in`=0110, coinciding with a valid bit that would have completed 1101: `o`=0 in that cycle. Stream 0,1,1,0 afterwards: `o`=1 on the 4th bit.
- `PAT_W`=4, `CNT_W`=2, pattern 1111, `overlap=1`, six 1s: `o`=1 on bits 4, 5 and 6; `match_cnt` saturates at 3 with `cnt_sat`=1. Then `clr_cnt` is asserted together with a match: next `match_cnt`=0.
- Reset asserted after bits 1,1,0 of 1101: with stream 1 next, `o`=0. With `SEQ_DETECT_CNT_EN` undefined, `match_cnt`=0 for the whole run.

Source files
------------

// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial sequence detector with runtime-loadable pattern.
// Optional saturating match counter built only when SEQ_DETECT_CNT_EN is defined.
module seq_detect_param #(
    parameter int                 PAT_W     = 4,
    parameter logic [PAT_W-1:0]   PAT_RESET = PAT_W'(4'b1101),
    parameter int                 CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i,
    input  logic             i_valid,
    input  logic             overlap,
    input  logic             load_pat,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clr_cnt,
    output logic             o,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  pat;
    logic [PAT_W-1:0]  cand;

    assign cand = {hist, i};

    // Reset is folded in so the flag stays low while stale history is being discarded.
    assign o = i_valid & ~load_pat & ~rst & (fill == FILL_MAX) & (cand == pat);

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
            pat  <= PAT_RESET;
        end else if (load_pat) begin
            pat  <= pat_in;
            hist <= '0;
            fill <= '0;
        end else if (i_valid) begin
            if (o && !overlap) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= cand[PAT_W-2:0];
                if (fill != FILL_MAX) begin
                    fill <= fill + FILL_W'(1);
                end
            end
        end
    end

`ifdef SEQ_DETECT_CNT_EN
    logic [CNT_W-1:0] cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A clear in the same cycle as a match wins; that match is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr_cnt) begin
            cnt <= '0;
        end else if (o) begin
            cnt <= sat_inc(cnt);
        end
    end

    assign match_cnt = cnt;
    assign cnt_sat   = &cnt;
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = clr_cnt;
    assign match_cnt      = '0;
    assign cnt_sat        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param (PAT_W=4, CNT_W=2); counter expectations
// follow whether SEQ_DETECT_CNT_EN is defined for the build.
module tb_seq_detect_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
    localparam logic [PAT_W-1:0] PAT_RST = 4'b1101;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i = 1'b0;
    logic             i_valid = 1'b0;
    logic             overlap = 1'b1;
    logic             load_pat = 1'b0;
    logic [PAT_W-1:0] pat_in = '0;
    logic             clr_cnt = 1'b0;
    logic             o;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    int total = 0;
    int bad   = 0;

    logic       exp_o_q[$];
    int         exp_cnt_q[$];

    // Reference model: list of accepted bits since the last clear, plus pattern and count.
    int               hq[$];
    logic [PAT_W-1:0] m_pat = PAT_RST;
    int               m_cnt = 0;
    logic             ov_g = 1'b1;

    seq_detect_param #(.PAT_W(PAT_W), .PAT_RESET(PAT_RST), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .overlap(overlap),
        .load_pat(load_pat), .pat_in(pat_in), .clr_cnt(clr_cnt),
        .o(o), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_o(input logic r, input logic v, input logic b, input logic ld);
        logic [PAT_W-1:0] c;
        int n;
        if (r || !v || ld) return 1'b0;
        n = hq.size();
        if (n < PAT_W - 1) return 1'b0;
        for (int k = 0; k < PAT_W - 1; k++) c[PAT_W-1-k] = hq[n-(PAT_W-1)+k][0];
        c[0] = b;
        return (c == m_pat);
    endfunction

    task automatic step(input logic r, input logic v, input logic b, input logic ov,
                        input logic ld, input logic [PAT_W-1:0] pi, input logic cc);
        logic eo;
        int   ec;
        @(posedge clk);
        #1;
        rst = r; i_valid = v; i = b; overlap = ov; load_pat = ld; pat_in = pi; clr_cnt = cc;
        eo = model_o(r, v, b, ld);
`ifdef SEQ_DETECT_CNT_EN
        ec = m_cnt;
`else
        ec = 0;
`endif
        exp_o_q.push_back(eo);
        exp_cnt_q.push_back(ec);
        @(negedge clk);
        ec = exp_cnt_q.pop_front();
        check("o", 32'(o), 32'(exp_o_q.pop_front()));
        check("match_cnt", 32'(match_cnt), 32'(ec));
        check("cnt_sat", 32'(cnt_sat), 32'(ec == (1 << CNT_W) - 1));
        // Advance model to the state seen after the coming edge.
        if (r) begin
            hq.delete(); m_pat = PAT_RST; m_cnt = 0;
        end else begin
            if (ld) begin
                m_pat = pi; hq.delete();
            end else if (v) begin
                if (eo && !ov) hq.delete();
                else begin
                    hq.push_back(int'(b));
                    if (hq.size() > PAT_W - 1) void'(hq.pop_front());
                end
            end
            if (cc) m_cnt = 0;
            else if (eo && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
    endtask

    task automatic bit_in(input logic b);
        step(1'b0, 1'b1, b, ov_g, 1'b0, '0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, ov_g, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, ov_g, 1'b0, '0, 1'b0);
    endtask

    task automatic stream(input logic [15:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) bit_in(bits[k]);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        do_reset();

        // Overlapping default pattern: matches on bits 4 and 7.
        ov_g = 1'b1;
        stream(16'b1101101, 7);
        idle();

        // Non-overlapping: match on bit 4 only, then a fresh 1101.
        do_reset();
        ov_g = 1'b0;
        stream(16'b1101101, 7);
        stream(16'b1101, 4);
        idle();

        // Valid gaps between bits.
        do_reset();
        ov_g = 1'b1;
        bit_in(1'b1); idle(); idle();
        bit_in(1'b1); idle();
        bit_in(1'b0); idle(); idle(); idle();
        bit_in(1'b1); idle();

        // Load coinciding with a completing bit, then the new pattern.
        do_reset();
        stream(16'b110, 3);
        step(1'b0, 1'b1, 1'b1, ov_g, 1'b1, 4'b0110, 1'b0);
        stream(16'b0110, 4);
        idle();

        // Self-overlapping 1111: saturation, then clear together with a match.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0);
        stream(16'b111111, 6);
        idle();
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        idle();
        ov_g = 1'b0;
        stream(16'b11111111, 8);

        // Reset in the middle of a partial sequence.
        do_reset();
        ov_g = 1'b1;
        stream(16'b110, 3);
        do_reset();
        bit_in(1'b1);
        stream(16'b1101, 4);
        idle();

        // Random mix of all controls.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 30) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
